// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU writes take priority over a FIFO of load results; starved loads raise stall_req.
// Optional macro WB_FWD_EN adds register-file read-port forwarding from the registered write port.
module wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alu_we,
   input  logic [4:0]              alu_rd,
   input  logic [31:0]             alu_wd,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [4:0]              ld_rd,
   input  logic [31:0]             ld_data,
   output logic                    WE3,
   output logic [4:0]              A3,
   output logic [31:0]             WD3,
`ifdef WB_FWD_EN
   input  logic [4:0]              A1,
   input  logic [4:0]              A2,
   output logic                    fwd1_hit,
   output logic                    fwd2_hit,
   output logic [31:0]             fwd1_data,
   output logic [31:0]             fwd2_data,
`endif
   output logic                    stall_req,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   // Each entry packs {rd, data}.
   logic [36:0]   mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [SW-1:0] starve_cnt;
   logic          alu_sel;
   logic          fifo_ne;
   logic          push;
   logic          pop;

   always_comb begin
      alu_sel   = alu_we && (alu_rd != '0);
      fifo_ne   = (fifo_count != '0);
      ld_ready  = (fifo_count != FULL);
      push      = ld_valid && ld_ready && (ld_rd != '0);
      pop       = !alu_sel && fifo_ne;
      stall_req = (starve_cnt == SMAX) && fifo_ne;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= {ld_rd, ld_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         starve_cnt <= '0;
         WE3        <= 1'b0;
         A3         <= '0;
         WD3        <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         WE3 <= alu_sel || fifo_ne;
         if (alu_sel) begin
            A3  <= alu_rd;
            WD3 <= alu_wd;
         end else if (fifo_ne) begin
            {A3, WD3} <= mem[rptr];
         end

         // Not popping with a non-empty FIFO implies the ALU won this edge.
         if (!fifo_ne || pop)
            starve_cnt <= '0;
         else if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

`ifdef WB_FWD_EN
   always_comb begin
      fwd1_hit  = WE3 && (A3 == A1) && (A1 != '0);
      fwd2_hit  = WE3 && (A3 == A2) && (A2 != '0);
      fwd1_data = WD3;
      fwd2_data = WD3;
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: a queue-based reference model predicts every write-port cycle.
// Define WB_FWD_EN to also exercise the forwarding outputs.
module tb_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int SMAX  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_we;
   logic [4:0]  alu_rd;
   logic [31:0] alu_wd;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        WE3;
   logic [4:0]  A3;
   logic [31:0] WD3;
   logic        stall_req;
   logic [2:0]  fifo_count;
`ifdef WB_FWD_EN
   logic [4:0]  A1, A2;
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;
`endif

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .WE3(WE3), .A3(A3), .WD3(WD3),
`ifdef WB_FWD_EN
      .A1(A1), .A2(A2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
      .stall_req(stall_req), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] d;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   exp_t expq[$];
   ent_t mq[$];
   int   starve = 0;
   int   pcnt = 0;
   int   checks = 0;
   int   failures = 0;

   logic        log_en = 1'b0;
   logic [4:0]  log_rd[$];
   logic [31:0] log_d[$];
   int          log_t[$];
   logic [4:0]  hold_a3 = '0;
   logic [31:0] hold_wd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: a plain queue of pending loads; ALU requests always win the write port.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         expq.delete();
         starve = 0;
      end else begin
         automatic bit   full = (mq.size() == DEPTH);
         automatic ent_t e;
         pcnt++;
         if (alu_we && alu_rd != 0) begin
            expq.push_back('{we: 1'b1, rd: alu_rd, d: alu_wd});
            starve = (mq.size() != 0) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
         end else if (mq.size() != 0) begin
            e = mq.pop_front();
            expq.push_back('{we: 1'b1, rd: e.rd, d: e.d});
            starve = 0;
         end else begin
            expq.push_back('{we: 1'b0, rd: 5'd0, d: 32'd0});
            starve = 0;
         end
         if (ld_valid && !full && ld_rd != 0)
            mq.push_back('{rd: ld_rd, d: ld_data});
      end
   end

   // Monitor: one expected write-port state per clock edge, compared away from the edge.
   always @(negedge clk) begin
      automatic exp_t e;
      if (reset) begin
         chk("rst_we3", 32'(WE3), 32'd0);
         chk("rst_a3", 32'(A3), 32'd0);
         chk("rst_wd3", WD3, 32'd0);
         hold_a3 = '0;
         hold_wd = '0;
      end else begin
         if (expq.size() > 0) e = expq.pop_front();
         else e = '{we: 1'b0, rd: 5'd0, d: 32'd0};
         chk("we3", 32'(WE3), 32'(e.we));
         if (e.we) begin
            hold_a3 = e.rd;
            hold_wd = e.d;
         end
         chk("a3", 32'(A3), 32'(hold_a3));
         chk("wd3", WD3, hold_wd);
         if (log_en && WE3) begin
            log_rd.push_back(A3);
            log_d.push_back(WD3);
            log_t.push_back(pcnt);
         end
      end
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("ld_ready", 32'(ld_ready), 32'(mq.size() != DEPTH));
      chk("stall_req", 32'(stall_req), 32'(starve == SMAX && mq.size() != 0));
   end

   task automatic set_in(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
      alu_we = aw; alu_rd = ar; alu_wd = ad;
      ld_valid = lv; ld_rd = lr; ld_data = ldd;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      reset = 1'b1;
      idle();
`ifdef WB_FWD_EN
      A1 = '0; A2 = '0;
`endif
      repeat (2) @(negedge clk);
      chk("reset_ld_ready", 32'(ld_ready), 32'd1);
      chk("reset_stall", 32'(stall_req), 32'd0);
      #2 reset = 1'b0;
      @(negedge clk);

      // Single ALU write: visible for exactly one cycle.
      set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("alu_we3", 32'(WE3), 32'd1);
      chk("alu_a3", 32'(A3), 32'd5);
      chk("alu_wd3", WD3, 32'hDEADBEEF);
      idle();
      @(negedge clk);
      chk("alu_we3_drop", 32'(WE3), 32'd0);

      // Four loads, ALU idle: in order, back to back, two cycles after first accept.
      log_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 32'h11));
         @(negedge clk);
         if (i == 1) p0 = pcnt;
      end
      idle();
      repeat (6) @(negedge clk);
      log_en = 1'b0;
      chk("ld_order_count", 32'(log_rd.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_rd.size(); i++) begin
         chk("ld_order_rd", 32'(log_rd[i]), 32'(i + 1));
         chk("ld_order_data", log_d[i], 32'((i + 1) * 32'h11));
         chk("ld_order_time", 32'(log_t[i]), 32'(p0 + 1 + i));
      end

      // Fill the FIFO under continuous ALU traffic, then drain.
      for (int i = 1; i <= 7; i++) begin
         set_in(1'b1, 5'd7, $urandom, 1'b1, (i <= 4) ? 5'(i) : 5'd8, $urandom);
         @(negedge clk);
      end
      chk("full_ld_ready", 32'(ld_ready), 32'd0);
      chk("full_stall", 32'(stall_req), 32'd1);
      chk("full_count", 32'(fifo_count), 32'd4);
      idle();
      repeat (6) @(negedge clk);
      chk("drain_ld_ready", 32'(ld_ready), 32'd1);
      chk("drain_count", 32'(fifo_count), 32'd0);

      // rd==0 on both channels is ignored.
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom);
         @(negedge clk);
         chk("zero_we3", 32'(WE3), 32'd0);
         chk("zero_count", 32'(fifo_count), 32'd0);
      end

      // Reset in the middle of a drain.
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b1, 5'd7, $urandom, 1'b1, 5'(i + 10), $urandom);
         @(negedge clk);
      end
      idle();
      @(negedge clk);
      chk("mid_count_pre", 32'(fifo_count), 32'd3);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_we3", 32'(WE3), 32'd0);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("mid_rst_stall", 32'(stall_req), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (4) @(negedge clk);

`ifdef WB_FWD_EN
      set_in(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      idle();
      A1 = 5'd9; A2 = 5'd0;
      #1;
      chk("fwd1_hit", 32'(fwd1_hit), 32'd1);
      chk("fwd1_data", fwd1_data, 32'h1234);
      chk("fwd2_hit_zero", 32'(fwd2_hit), 32'd0);
      A2 = 5'd9; A1 = 5'd3;
      #1;
      chk("fwd2_hit", 32'(fwd2_hit), 32'd1);
      chk("fwd1_miss", 32'(fwd1_hit), 32'd0);
      @(negedge clk);
`endif

      // Random traffic, alternating ALU-heavy and ALU-light phases.
      for (int blk = 0; blk < 16; blk++) begin
         int alu_pct = (blk % 2 == 0) ? 90 : 25;
         for (int c = 0; c < 200; c++) begin
            set_in($urandom_range(0, 99) < alu_pct,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom,
                   $urandom_range(0, 99) < 60,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
            if ($urandom_range(0, 499) == 0) begin
               #2 reset = 1'b1;
               @(negedge clk);
               #2 reset = 1'b0;
            end
            @(negedge clk);
         end
      end

      idle();
      repeat (8) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, load-result FIFO entries, power of two, range 2..16.
REQ-002 SHALL have parameter STARVE_MAX, default 3, consecutive ALU-won cycles tolerated before a stall request.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: alu_we in 1, alu_rd in 5, alu_wd in 32; single-cycle ALU/jump writeback request.
REQ-006 SHALL have ports: ld_valid in 1, ld_ready out 1, ld_rd in 5, ld_data in 32; load-result valid/ready channel.
REQ-007 SHALL have ports: WE3 out 1, A3 out 5, WD3 out 32; register file write port, all registered.
REQ-008 SHALL have ports: stall_req out 1, fifo_count out $clog2(DEPTH)+1; pipeline stall request and FIFO occupancy.

Function
REQ-009 SHALL accept a load when ld_valid && ld_ready at a rising edge; ld_ready = (fifo_count != DEPTH), from registered count only.
REQ-010 SHALL discard accepted loads with ld_rd == 0 (handshake completes, nothing enqueued).
REQ-011 SHALL each cycle select: ALU if alu_we && alu_rd != 0; else FIFO head if non-empty; else none.
REQ-012 SHALL register the selection at the edge: WE3=1, A3/WD3 = selected rd/data; WE3=0 when none selected (A3/WD3 hold).
REQ-013 SHALL give ALU latency 1: request in cycle N -> WE3 high in cycle N+1.
REQ-014 SHALL give load latency >= 2: accepted at edge ending cycle N -> earliest WE3 in cycle N+2.
REQ-015 SHALL pop the FIFO head only when it is selected; FIFO order strictly preserved.
REQ-016 SHALL handle simultaneous push and pop in one edge, count unchanged; push when full never occurs (REQ-009).
REQ-017 SHALL never drop an ALU request (alu_we, alu_rd != 0), even while stall_req is high.
REQ-018 SHALL keep starve_cnt: +1 (saturating at STARVE_MAX) each edge ALU wins with FIFO non-empty; cleared on FIFO pop or FIFO empty.
REQ-019 SHALL drive stall_req = (starve_cnt == STARVE_MAX) && FIFO non-empty, combinationally from registers.
REQ-020 SHALL wrap read/write pointers modulo DEPTH.
REQ-021 SHALL ignore alu_we with alu_rd == 0 entirely (no write, no starve count).

Reset
REQ-022 SHALL on reset assertion immediately clear WE3, A3, WD3, FIFO pointers, fifo_count, starve_cnt to 0.
REQ-023 SHALL drive ld_ready=1 and stall_req=0 while and after reset; in-flight FIFO contents lost on mid-operation reset.
REQ-024 SHALL release reset with no write in the first post-reset cycle.

Configuration
REQ-025 SHALL, with WB_FWD_EN defined, add inputs A1, A2 (5) and outputs fwd1_hit, fwd2_hit (1), fwd1_data, fwd2_data (32).
REQ-026 SHALL, with WB_FWD_EN defined, drive fwdN_hit = WE3 && A3 == AN && AN != 0, fwdN_data = WD3, combinational.
REQ-027 SHALL, without WB_FWD_EN, omit those ports and logic; all other behaviour identical.

Verification
REQ-028 SHALL test: alu_we=1, alu_rd=5, alu_wd=0xDEADBEEF in cycle 1 -> WE3=1, A3=5, WD3=0xDEADBEEF in cycle 2 only.
REQ-029 SHALL test: loads rd=1..4, data 0x11..0x44, DEPTH=4, ALU idle -> written in order 1,2,3,4, one per cycle, starting two cycles after first accept.
REQ-030 SHALL test: FIFO full (4 loads, alu_we held with rd=7) -> ld_ready=0, stall_req=1 after 3 ALU-won cycles; dropping alu_we drains FIFO, ld_ready returns to 1.
REQ-031 SHALL test: ld_rd=0 accepted and alu_rd=0 with alu_we=1 -> WE3 stays 0, fifo_count stays 0.
REQ-032 SHALL test: reset asserted mid-drain with fifo_count=3 -> WE3=0, fifo_count=0, ld_ready=1 same cycle; no stale write after release.
REQ-033 SHALL test, with WB_FWD_EN: WE3=1, A3=9, WD3=0x1234, A1=9, A2=0 -> fwd1_hit=1, fwd1_data=0x1234, fwd2_hit=0.
